// File: rtl/scoreboard_hazard_unit.sv
// Scoreboard hazard unit: per-register countdown counters for
// variable-latency producers, driving stall, bypass and flush recovery.
module scoreboard_hazard_unit #(
    parameter int NUM_REGS    = 32,
    parameter int REG_W       = 5,
    parameter int MAX_LAT     = 8,
    parameter int CNT_W       = 4,
    parameter int BYPASS      = 1,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iss_valid_i,
    input  logic [REG_W-1:0] iss_rs_i,
    input  logic [REG_W-1:0] iss_rt_i,
    input  logic             iss_rs_used_i,
    input  logic             iss_rt_used_i,
    input  logic [REG_W-1:0] iss_rd_i,
    input  logic             iss_reg_wr_i,
    input  logic [CNT_W-1:0] iss_lat_i,
    input  logic             flush_i,
    output logic             stall_fetch_o,
    output logic             stall_iss_o,
    output logic             fwd_rs_o,
    output logic             fwd_rt_o,
    output logic             iss_fire_o,
    output logic             busy_o,
    output logic [31:0]      stall_cnt_o
);

    localparam logic [CNT_W-1:0] LAT_MAX = CNT_W'(MAX_LAT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] cnt [NUM_REGS];
    logic             hist_valid [FLUSH_DEPTH];
    logic [REG_W-1:0] hist_rd    [FLUSH_DEPTH];
    logic [31:0]      stall_cnt;

    logic [CNT_W-1:0] cnt_rs;
    logic [CNT_W-1:0] cnt_rt;
    logic [CNT_W-1:0] cnt_rd;
    logic [CNT_W-1:0] lat;
    logic             rs_nz;
    logic             rt_nz;
    logic             rd_nz;
    logic             raw_rs;
    logic             raw_rt;
    logic             waw;
    logic             stall;
    logic             fire;
    logic             load;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] ld_mask;

    assign cnt_rs = cnt[iss_rs_i];
    assign cnt_rt = cnt[iss_rt_i];
    assign cnt_rd = cnt[iss_rd_i];

    assign rs_nz = (iss_rs_i != '0);
    assign rt_nz = (iss_rt_i != '0);
    assign rd_nz = (iss_rd_i != '0);

    // Out-of-range latencies are clamped to the slowest producer
    always_comb begin
        lat = iss_lat_i;
        if (iss_lat_i == '0 || iss_lat_i > LAT_MAX) begin
            lat = LAT_MAX;
        end
    end

    // Hazard detection: RAW on each source, WAW for in-order completion
    always_comb begin
        raw_rs = 1'b0;
        raw_rt = 1'b0;
        if (BYPASS != 0) begin
            raw_rs = iss_rs_used_i & rs_nz & (cnt_rs > ONE);
            raw_rt = iss_rt_used_i & rt_nz & (cnt_rt > ONE);
        end else begin
            raw_rs = iss_rs_used_i & rs_nz & (cnt_rs != '0);
            raw_rt = iss_rt_used_i & rt_nz & (cnt_rt != '0);
        end
        waw   = iss_reg_wr_i & rd_nz & (cnt_rd > lat);
        stall = iss_valid_i & ~flush_i & (raw_rs | raw_rt | waw);
        fire  = iss_valid_i & ~stall & ~flush_i;
        load  = fire & iss_reg_wr_i & rd_nz;
    end

    // Bypass selects, suppressed while the issue is held
    always_comb begin
        fwd_rs_o = 1'b0;
        fwd_rt_o = 1'b0;
        if (BYPASS != 0 && !stall) begin
            fwd_rs_o = iss_rs_used_i & rs_nz & (cnt_rs == ONE);
            fwd_rt_o = iss_rt_used_i & rt_nz & (cnt_rt == ONE);
        end
    end

    assign stall_fetch_o = stall;
    assign stall_iss_o   = stall;
    assign iss_fire_o    = fire;
    assign stall_cnt_o   = stall_cnt;

    // Registers to clear on flush and register to load on fire
    always_comb begin
        clr_mask = '0;
        ld_mask  = '0;
        if (flush_i) begin
            for (int h = 0; h < FLUSH_DEPTH; h++) begin
                if (hist_valid[h]) begin
                    clr_mask[hist_rd[h]] = 1'b1;
                end
            end
        end
        if (load) begin
            ld_mask[iss_rd_i] = 1'b1;
        end
    end

    // Any outstanding producer keeps the unit busy
    always_comb begin
        busy_o = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            busy_o = busy_o | (cnt[r] != '0);
        end
    end

    // Countdown counters: flush clear beats load beats decrement
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            cnt[0] <= '0;
            for (int r = 1; r < NUM_REGS; r++) begin
                if (clr_mask[r]) begin
                    cnt[r] <= '0;
                end else if (ld_mask[r]) begin
                    cnt[r] <= lat;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - ONE;
                end
            end
        end
    end

    // Issue history: newest at index 0, wiped on flush
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int h = 0; h < FLUSH_DEPTH; h++) begin
                hist_valid[h] <= 1'b0;
                hist_rd[h]    <= '0;
            end
        end else begin
            hist_valid[0] <= load & ~flush_i;
            hist_rd[0]    <= iss_rd_i;
            for (int h = 1; h < FLUSH_DEPTH; h++) begin
                hist_valid[h] <= hist_valid[h-1] & ~flush_i;
                hist_rd[h]    <= hist_rd[h-1];
            end
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule
